// File: rtl/ifetch_prefetch_pkg.sv
// Shared constants for the instruction fetch / prefetch unit.
package ifetch_prefetch_pkg;

  localparam int unsigned INST_WIDTH      = 32;
  localparam int unsigned PC_STEP         = 4;
  localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifetch_prefetch_fifo.sv
// Prefetch FIFO holding {pc, inst} pairs; head is a register read, no bypass.
module ifetch_fifo
  import ifetch_prefetch_pkg::*;
#(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [W-1:0]                push_data,
  input  logic                        pop,
  input  logic                        flush,
  output logic [$clog2(DEPTH):0]      count,
  output logic [W-1:0]                head_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; head is masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifetch_prefetch.sv
// Sequential instruction prefetcher: credit-limited requests, in-order responses,
// redirect flushes the queue and discards responses still in flight.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFETCH_RESET_PC),
  parameter int unsigned     DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [XLEN-1:0]       imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_pc_plus_4
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 2;
  localparam int unsigned FW = XLEN + INST_WIDTH;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [FW-1:0]   head;
  logic [XLEN-1:0] redirect_base;
  logic [SW-1:0]   discard_sum;
  logic            grant;
  logic            keep;
  logic            drop;
  logic            pop;

  assign imem_req  = !rst && ((SW'(count) + SW'(outstanding)) < SW'(DEPTH));
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;
  assign keep      = imem_rvalid && (discard == '0) && !redirect_valid;
  assign drop      = imem_rvalid && (discard != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;

  assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};
  // Everything granted but not yet returned becomes stale on a redirect.
  assign discard_sum   = SW'(discard) + SW'(outstanding) + SW'(grant) - SW'(imem_rvalid);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= {RESET_PC[XLEN-1:2], 2'b00};
      resp_pc     <= {RESET_PC[XLEN-1:2], 2'b00};
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_base;
      resp_pc     <= redirect_base;
      outstanding <= '0;
      discard     <= CW'(discard_sum);
    end else begin
      if (grant) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      if (keep)  resp_pc  <= resp_pc + XLEN'(PC_STEP);
      if (drop)  discard  <= discard - CW'(1);
      outstanding <= outstanding + CW'(grant) - CW'(keep);
    end
  end

  ifetch_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (keep),
    .push_data ({resp_pc, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head_data (head)
  );

  assign out_valid     = (count != '0);
  assign out_inst      = head[INST_WIDTH-1:0];
  assign out_pc        = head[FW-1:INST_WIDTH];
  assign out_pc_plus_4 = out_valid ? (out_pc + XLEN'(PC_STEP)) : '0;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with an in-order fixed-latency memory model.
module tb_ifetch_prefetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  logic [31:0] pp[$];
  logic [31:0] pi[$];
  logic [31:0] pp4[$];
  int          pcyc[$];
  logic [31:0] gq[$];
  int          cyc    = 0;
  int          lat    = 1;
  bit          gnt_en = 0;

  ifetch_prefetch #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0100),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pc_plus_4  (out_pc_plus_4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // A response the fetch unit has no slot for is a memory-side protocol error.
  always @(negedge clk) begin
    if (!rst && imem_rvalid && dut.discard == '0 && dut.outstanding == '0) begin
      total++;
      bad++;
      $display("FAIL protocol: rvalid with no outstanding or discard slot at t=%0t", $time);
    end
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  // One clock: drive inputs, sample outputs mid-cycle, advance the memory model.
  task automatic cycle(input bit redir, input logic [31:0] rpc);
    logic        g;
    logic        rv;
    logic [31:0] ga;
    imem_gnt = gnt_en;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inst_of(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    g  = imem_req && imem_gnt;
    ga = imem_addr;
    rv = imem_rvalid;
    if (out_valid && out_ready && !redir) begin
      pp.push_back(out_pc);
      pi.push_back(out_inst);
      pp4.push_back(out_pc_plus_4);
      pcyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
    end else begin
      if (rv) void'(mq.pop_front());
      if (g) begin
        mq.push_back('{addr: ga, due: cyc + lat});
        gq.push_back(ga);
      end
    end
    redirect_valid = 1'b0;
    cyc++;
  endtask

  task automatic clear_logs();
    pp.delete();
    pi.delete();
    pp4.delete();
    pcyc.delete();
    gq.delete();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    gnt_en    = 0;
    out_ready = 1'b0;
    cycle(0, 32'h0);
    cycle(0, 32'h0);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    gnt_en = 0;
    out_ready = 1'b0;
    cycle(0, 32'h0);
    cycle(0, 32'h0);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL reset_addr: got %h want 00000100", imem_addr); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
    total++; if (out_pc_plus_4 !== 32'h0) begin bad++; $display("FAIL reset_pc4: got %h want 0", out_pc_plus_4); end
    rst = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_release_req: got %0b want 1", imem_req); end
    clear_logs();
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; gnt_en = 1; out_ready = 1'b1;
    repeat (12) cycle(0, 32'h0);
    total++; if (pp.size() < 8) begin bad++; $display("FAIL stream_count: got %0d want >=8", pp.size()); end
    for (int i = 0; i < 8 && i < pp.size(); i++) begin
      total++; if (pp[i] !== 32'h100 + 32'(4*i)) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pp[i], 32'h100 + 32'(4*i)); end
      total++; if (pp4[i] !== 32'h104 + 32'(4*i)) begin bad++; $display("FAIL stream_pc4[%0d]: got %h want %h", i, pp4[i], 32'h104 + 32'(4*i)); end
      total++; if (pi[i] !== inst_of(32'h100 + 32'(4*i))) begin bad++; $display("FAIL stream_inst[%0d]: got %h want %h", i, pi[i], inst_of(32'h100 + 32'(4*i))); end
    end
    if (pcyc.size() >= 8) begin
      total++; if (pcyc[7] - pcyc[0] != 7) begin bad++; $display("FAIL stream_rate: got %0d cycles for 7 pops want 7", pcyc[7] - pcyc[0]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    cycle(1, 32'h0);
    gnt_en = 1; lat = 1;
    clear_logs();
    repeat (10) cycle(0, 32'h0);
    total++; if (gq.size() != 4) begin bad++; $display("FAIL bp_grants: got %0d want 4", gq.size()); end
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      total++; if (gq[i] !== 32'(4*i)) begin bad++; $display("FAIL bp_addr[%0d]: got %h want %h", i, gq[i], 32'(4*i)); end
    end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_full: got %0b want 0", imem_req); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_full: got %0b want 1", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL bp_head_pc: got %h want 0", out_pc); end
    out_ready = 1'b1;
    repeat (8) cycle(0, 32'h0);
    total++; if (pp.size() < 4) begin bad++; $display("FAIL bp_pops: got %0d want >=4", pp.size()); end
    for (int i = 0; i < 4 && i < pp.size(); i++) begin
      total++; if (pp[i] !== 32'(4*i)) begin bad++; $display("FAIL bp_pop_pc[%0d]: got %h want %h", i, pp[i], 32'(4*i)); end
    end
    total++; if (gq.size() < 5 || gq[4] !== 32'h10) begin bad++; $display("FAIL bp_resume: got %0d grants, want fifth at 00000010", gq.size()); end
  endtask

  task automatic test_redirect_latency();
    do_reset();
    lat = 5; gnt_en = 1; out_ready = 1'b1;
    repeat (3) cycle(0, 32'h0);
    gnt_en = 0;
    cycle(1, 32'h2002);
    total++; if (imem_addr !== 32'h2000) begin bad++; $display("FAIL rl_addr: got %h want 00002000", imem_addr); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rl_req: got %0b want 1", imem_req); end
    total++; if (dut.discard !== 3'd3) begin bad++; $display("FAIL rl_discard: got %0d want 3", dut.discard); end
    gnt_en = 1;
    repeat (25) cycle(0, 32'h0);
    total++; if (pp.size() < 3) begin bad++; $display("FAIL rl_pops: got %0d want >=3", pp.size()); end
    for (int i = 0; i < 3 && i < pp.size(); i++) begin
      total++; if (pp[i] !== 32'h2000 + 32'(4*i)) begin bad++; $display("FAIL rl_pc[%0d]: got %h want %h", i, pp[i], 32'h2000 + 32'(4*i)); end
    end
    if (pi.size() > 0) begin
      total++; if (pi[0] !== inst_of(32'h2000)) begin bad++; $display("FAIL rl_inst0: got %h want %h", pi[0], inst_of(32'h2000)); end
    end
  endtask

  task automatic test_redirect_collision();
    int stale;
    do_reset();
    lat = 2; gnt_en = 1; out_ready = 1'b1;
    repeat (2) cycle(0, 32'h0);
    cycle(1, 32'h3000);
    total++; if (dut.discard !== 3'd2) begin bad++; $display("FAIL col_discard: got %0d want 2", dut.discard); end
    total++; if (dut.outstanding !== 3'd0) begin bad++; $display("FAIL col_outstanding: got %0d want 0", dut.outstanding); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL col_valid: got %0b want 0", out_valid); end
    repeat (15) cycle(0, 32'h0);
    stale = 0;
    foreach (pp[i]) if (pp[i] < 32'h3000) stale++;
    total++; if (stale != 0) begin bad++; $display("FAIL col_stale: got %0d stale pops want 0", stale); end
    total++; if (pp.size() == 0 || pp[0] !== 32'h3000) begin bad++; $display("FAIL col_first: got %0d pops, want first at 00003000", pp.size()); end
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 1; gnt_en = 1; out_ready = 1'b1;
    cycle(1, 32'hFFFF_FFF8);
    repeat (10) cycle(0, 32'h0);
    total++; if (pp.size() < 3) begin bad++; $display("FAIL wrap_pops: got %0d want >=3", pp.size()); end
    if (pp.size() >= 3) begin
      total++; if (pp[0] !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_pc0: got %h want fffffff8", pp[0]); end
      total++; if (pp[1] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc1: got %h want fffffffc", pp[1]); end
      total++; if (pp[2] !== 32'h0) begin bad++; $display("FAIL wrap_pc2: got %h want 00000000", pp[2]); end
      total++; if (pp4[0] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc4_0: got %h want fffffffc", pp4[0]); end
      total++; if (pp4[1] !== 32'h0) begin bad++; $display("FAIL wrap_pc4_1: got %h want 00000000", pp4[1]); end
      total++; if (pi[2] !== inst_of(32'h0)) begin bad++; $display("FAIL wrap_inst2: got %h want %h", pi[2], inst_of(32'h0)); end
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid: got %0b want 1", out_valid); end
    cycle(1, 32'h500);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 4; gnt_en = 1; out_ready = 1'b1;
    repeat (2) cycle(0, 32'h0);
    cycle(1, 32'h4000);
    cycle(1, 32'h5000);
    total++; if (dut.discard !== 3'd4) begin bad++; $display("FAIL b2b_discard: got %0d want 4", dut.discard); end
    total++; if (imem_addr !== 32'h5000) begin bad++; $display("FAIL b2b_addr: got %h want 00005000", imem_addr); end
    repeat (25) cycle(0, 32'h0);
    total++; if (pp.size() < 2) begin bad++; $display("FAIL b2b_pops: got %0d want >=2", pp.size()); end
    if (pp.size() >= 2) begin
      total++; if (pp[0] !== 32'h5000) begin bad++; $display("FAIL b2b_pc0: got %h want 00005000", pp[0]); end
      total++; if (pp[1] !== 32'h5004) begin bad++; $display("FAIL b2b_pc1: got %h want 00005004", pp[1]); end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    lat = 3; gnt_en = 1; out_ready = 1'b1;
    repeat (4) cycle(0, 32'h0);
    rst = 1'b1;
    gnt_en = 0;
    cycle(0, 32'h0);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mid_req: got %0b want 0", imem_req); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %0b want 0", out_valid); end
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL mid_addr: got %h want 00000100", imem_addr); end
    rst = 1'b0;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 32'h0);
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL mid_hold[%0d]: got req=%0b addr=%h want req=1 addr=00000100", i, imem_req, imem_addr); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_hold_valid[%0d]: got %0b want 0", i, out_valid); end
    end
    gnt_en = 1;
    repeat (8) cycle(0, 32'h0);
    total++; if (pp.size() < 2 || pp[0] !== 32'h100 || pp[1] !== 32'h104) begin bad++; $display("FAIL mid_restart: got %0d pops, want 00000100 then 00000104", pp.size()); end
  endtask

  initial begin
    rst            = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_latency();
    test_redirect_collision();
    test_wrap();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
